ahb_lite_sram_slave: RTL

//  Parametrised AHB-Lite slave with a word-organised on-chip SRAM behind the SoC-FPGA AHB slave interface.

---
 rtl/ahb_lite_sram_slave.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave
//   AHB-Lite slave fronting a word-organised on-chip SRAM. Supports
//   configurable wait states, byte-lane write enables, pipelined
//   back-to-back transfers and a two-cycle ERROR response.
//
// Ports
//   HCLK, HRESETN_I        clock (rising edge) / asynchronous active-low reset
//   HSEL, HADDR, HTRANS,   address-phase controls, sampled when HREADY is high
//   HWRITE, HSIZE, HBURST,
//   HPROT, HMASTLOCK       (HBURST/HPROT/HMASTLOCK are accepted but unused)
//   HREADY                 bus-level ready
//   HWBE, HWDATA           data-phase byte enables and write data
//   HRDATA                 read data, non-zero only in the data cycle of a read
//   HREADYOUT, HRESP       slave ready / response (0 OKAY, 1 ERROR)
module ahb_lite_sram_slave #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESETN_I,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic                    HMASTLOCK,
  input  logic                    HREADY,
  input  logic [DATA_WIDTH/8-1:0] HWBE,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP
);

  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(STRB_W);
  localparam int IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t              state_q, state_d;
  logic [2:0]          wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wr_q, wr_d;
  logic [STRB_W-1:0]   lane_mask_q, lane_mask_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rd_mem_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [STRB_W-1:0]     fwd_en_q, fwd_en_d;

  logic [ADDR_WIDTH-1:0] offset, word_off;
  logic [7:0]            size_bytes;
  logic [2:0]            align_bits;
  logic [15:0]           lane_fill, lane_shift;
  logic                  in_range, size_ok, aligned, legal, accept;
  logic [IDX_W-1:0]      acc_idx;
  logic [STRB_W-1:0]     acc_mask;
  logic                  wr_commit, rd_capture;
  logic [STRB_W-1:0]     wr_lane_en;
  logic [DATA_WIDTH-1:0] rd_word, rd_lane;
  logic                  unused_ok;

  // Address-phase decode: legality check, word index and size/address lane mask.
  always_comb begin
    offset     = HADDR - BASE_ADDR;
    word_off   = offset >> BYTE_SHIFT;
    in_range   = (HADDR >= BASE_ADDR) && (word_off < ADDR_WIDTH'(DEPTH_WORDS));
    size_ok    = (HSIZE <= 3'(BYTE_SHIFT));
    size_bytes = 8'd1 << HSIZE;
    // Low-address bits that must be zero for the transfer size.
    align_bits = size_bytes[2:0] - 3'd1;
    aligned    = ((HADDR[2:0] & align_bits) == 3'd0);
    legal      = in_range && size_ok && aligned;
    acc_idx    = word_off[IDX_W-1:0];
    lane_fill  = (16'd1 << size_bytes) - 16'd1;
    lane_shift = lane_fill << HADDR[BYTE_SHIFT-1:0];
    acc_mask   = lane_shift[STRB_W-1:0];
    accept     = HSEL && HTRANS[1] && HREADY;
  end

  // Next-state logic. IDLE, DATA and ERR2 all drive HREADYOUT high, so any
  // of them can take the next address phase.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    lane_mask_d = lane_mask_q;
    case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q == 3'd0) state_d = ST_DATA;
        else                    wait_cnt_d = wait_cnt_q - 3'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (accept) begin
          wr_d = HWRITE;
          if (legal) begin
            idx_d       = acc_idx;
            lane_mask_d = acc_mask;
            if (WAIT_STATES > 0) begin
              state_d    = ST_WAIT;
              wait_cnt_d = 3'(WAIT_STATES - 1);
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_ERR1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN_I) begin
    if (!HRESETN_I) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 3'd0;
      idx_q       <= '0;
      wr_q        <= 1'b0;
      lane_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      lane_mask_q <= lane_mask_d;
    end
  end

  // A write commits at the edge ending its DATA cycle. The read word is
  // captured at the edge entering DATA; if a write to the same word commits
  // on that same edge, its enabled lanes are forwarded so the read sees the
  // new data.
  always_comb begin
    wr_commit  = (state_q == ST_DATA) && wr_q;
    wr_lane_en = HWBE & lane_mask_q;
    rd_capture = (state_d == ST_DATA);
    fwd_en_d   = (wr_commit && (idx_q == idx_d)) ? wr_lane_en : '0;
  end

  always_ff @(posedge HCLK) begin
    if (wr_commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_lane_en[b]) mem[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
      end
    end
    if (rd_capture) begin
      rd_mem_q   <= mem[idx_d];
      fwd_data_q <= HWDATA;
      fwd_en_q   <= fwd_en_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      assign rd_word[gi*8 +: 8] = fwd_en_q[gi] ? fwd_data_q[gi*8 +: 8] : rd_mem_q[gi*8 +: 8];
      assign rd_lane[gi*8 +: 8] = rd_word[gi*8 +: 8] & {8{lane_mask_q[gi]}};
    end
  endgenerate

  always_comb begin
    HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    HRDATA    = ((state_q == ST_DATA) && !wr_q) ? rd_lane : '0;
  end

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], lane_shift[15:STRB_W]};

endmodule
